ex_stage: RTL

Execute stage of the 5-stage RV32 pipeline, sitting between the ID/EX and EX/MEM pipeline registers. It consumes the ID/EX outputs and computes:
- the ALU result and zero flag;
- the branch target;
- the passthrough data and control bundle for EX/MEM.

RV32M `MUL` (low 32 bits) is executed by an iterative shift-add multiplier. While it runs, the stage raises `stall` to freeze PC, IF/ID and ID/EX, and drives a bubble downstream.

---
 rtl/ex_pkg.sv | 32 +++
 rtl/ex_stage_mul_seq.sv | 90 +++++++++
 rtl/ex_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU function codes, ALU op classes
// and the multiplier sequencer states.
package ex_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int MUL_CYCLES   = XLEN_DEFAULT;

    // EX_ALU_Op classes
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_ITYPE = 2'b11;

    // {funct7[5], funct3} function codes
    localparam logic [3:0] FN_ADD  = 4'b0000;
    localparam logic [3:0] FN_SUB  = 4'b1000;
    localparam logic [3:0] FN_AND  = 4'b0111;
    localparam logic [3:0] FN_OR   = 4'b0110;
    localparam logic [3:0] FN_XOR  = 4'b0100;
    localparam logic [3:0] FN_SLL  = 4'b0001;
    localparam logic [3:0] FN_SRL  = 4'b0101;
    localparam logic [3:0] FN_SRA  = 4'b1101;
    localparam logic [3:0] FN_SLT  = 4'b0010;
    localparam logic [3:0] FN_SLTU = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/ex_stage_mul_seq.sv
// Iterative shift-add multiplier (low XLEN bits) with its sequencing FSM.
//   state | meaning
//   IDLE  | waiting for start; operands latched on start
//   BUSY  | one shift-add step per cycle, XLEN steps total
//   DONE  | product valid for one cycle, then back to IDLE
module mul_seq
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    mul_state_t      r_state, w_state_nxt;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic [XLEN-1:0] r_acc, w_acc_nxt;
    logic [XLEN-1:0] r_mcand, w_mcand_nxt;
    logic [XLEN-1:0] r_mplier, w_mplier_nxt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        if (flush) begin
            // Partial product is dropped; the instruction is being killed.
            w_state_nxt = IDLE;
            w_count_nxt = '0;
            w_acc_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_nxt  = BUSY;
                        w_count_nxt  = '0;
                        w_acc_nxt    = '0;
                        w_mcand_nxt  = a;
                        w_mplier_nxt = b;
                    end
                end
                BUSY: begin
                    if (r_mplier[0]) begin
                        w_acc_nxt = r_acc + r_mcand;
                    end
                    w_mcand_nxt  = r_mcand << 1;
                    w_mplier_nxt = r_mplier >> 1;
                    w_count_nxt  = r_count + 1'b1;
                    if (r_count == LAST) begin
                        w_state_nxt = DONE;
                    end
                end
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign busy    = (r_state == BUSY);
    assign done    = (r_state == DONE);
    assign product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// RV32 execute stage: ALU, branch target, EX/MEM passthrough, and the stall /
// bubble handling around the sequential MUL unit.
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [3:0]      funct_inst_bits,
    input  logic            mul_en,
    input  logic [4:0]      rd,
    input  logic            WB_reg_write,
    input  logic            WB_mem_to_reg,
    input  logic            M_branch,
    input  logic            M_mem_read,
    input  logic            M_mem_write,
    input  logic [1:0]      EX_ALU_Op,
    input  logic            EX_ALU_Src,
    input  logic            flush,
    output logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] rs2_fwd,
    output logic [4:0]      rd_out,
    output logic            WB_reg_write_out,
    output logic            WB_mem_to_reg_out,
    output logic            M_branch_out,
    output logic            M_mem_read_out,
    output logic            M_mem_write_out
);

    logic            w_busy;
    logic            w_done;
    logic            w_issue;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_product;
    logic [3:0]      w_fn;
    logic [4:0]      w_shamt;

    assign w_op_b  = EX_ALU_Src ? imm : rs2_data;
    assign w_shamt = w_op_b[4:0];

    always_comb begin
        w_alu = '0;
        w_fn  = funct_inst_bits;
        // I-type has no subtract; funct7[5] there is immediate bits.
        if (EX_ALU_Op == OP_ITYPE && funct_inst_bits == FN_SUB) begin
            w_fn = FN_ADD;
        end
        case (EX_ALU_Op)
            OP_ADD: w_alu = rs1_data + w_op_b;
            OP_SUB: w_alu = rs1_data - w_op_b;
            default: begin
                case (w_fn)
                    FN_ADD:  w_alu = rs1_data + w_op_b;
                    FN_SUB:  w_alu = rs1_data - w_op_b;
                    FN_AND:  w_alu = rs1_data & w_op_b;
                    FN_OR:   w_alu = rs1_data | w_op_b;
                    FN_XOR:  w_alu = rs1_data ^ w_op_b;
                    FN_SLL:  w_alu = rs1_data << w_shamt;
                    FN_SRL:  w_alu = rs1_data >> w_shamt;
                    FN_SRA:  w_alu = $signed(rs1_data) >>> w_shamt;
                    FN_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(rs1_data) < $signed(w_op_b)};
                    FN_SLTU: w_alu = {{(XLEN-1){1'b0}}, rs1_data < w_op_b};
                    default: w_alu = '0;
                endcase
            end
        endcase
    end

    assign w_issue = reset & in_valid & mul_en & (EX_ALU_Op == OP_RTYPE)
                   & !w_busy & !w_done & !flush;

    mul_seq #(.XLEN(XLEN)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (w_issue),
        .flush   (flush),
        .a       (rs1_data),
        .b       (rs2_data),
        .busy    (w_busy),
        .done    (w_done),
        .product (w_product)
    );

    // A flush releases the stall in the same cycle so upstream can refill.
    assign stall     = reset & (w_issue | (w_busy & !flush));
    assign out_valid = reset & !flush & !stall & (w_done | in_valid);

    assign alu_result    = w_done ? w_product : w_alu;
    assign zero          = (alu_result == '0);
    assign branch_target = pc + imm;
    assign rs2_fwd       = rs2_data;

    assign rd_out            = stall ? 5'd0 : rd;
    assign WB_reg_write_out  = !stall & WB_reg_write;
    assign WB_mem_to_reg_out = !stall & WB_mem_to_reg;
    assign M_branch_out      = !stall & M_branch;
    assign M_mem_read_out    = !stall & M_mem_read;
    assign M_mem_write_out   = !stall & M_mem_write;

endmodule
